// File: rtl/vend_ctrl.sv
// Vending machine controller: coin credit accumulation, product vend handshake,
// and one-coin-per-handshake change return using 10/5/1 denominations.
module vend_ctrl #(
   parameter int CREDIT_W   = 8,
   parameter int N_ITEMS    = 4,
   parameter int IDX_W      = 2,
   parameter int PRICE_BASE = 5,
   parameter int PRICE_STEP = 5,
   parameter int MAX_CREDIT = 99
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin1,
   input  logic                coin5,
   input  logic                coin10,
   input  logic                sel_valid,
   input  logic [IDX_W-1:0]    sel_idx,
   input  logic                cancel,
   output logic                vend_valid,
   output logic [IDX_W-1:0]    vend_idx,
   input  logic                vend_ready,
   output logic                chg_valid,
   output logic [1:0]          chg_coin,
   input  logic                chg_ready,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_rej,
   output logic                sel_deny
);

   localparam int AW = CREDIT_W + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEND   = 2'd1,
      CHANGE = 2'd2
   } state_t;

   state_t              state_r, state_s;
   logic [CREDIT_W-1:0] credit_r, credit_s;
   logic [IDX_W-1:0]    vend_idx_r, vend_idx_s;
   logic                vend_valid_r, chg_valid_r;
   logic [1:0]          chg_coin_r;
   logic                coin_rej_r, coin_rej_s;
   logic                sel_deny_r, sel_deny_s;
   logic [AW-1:0]       credit_ext_s, sum_s, coined_s, price_s, paid_s;
   logic                any_coin_s;

   function automatic logic [AW-1:0] price_of(input logic [IDX_W-1:0] idx);
      price_of = AW'(PRICE_BASE) + AW'(idx) * AW'(PRICE_STEP);
   endfunction

   // Largest denomination not exceeding the remaining credit.
   function automatic logic [1:0] coin_code(input logic [AW-1:0] c);
      if (c >= AW'(10)) begin
         coin_code = 2'd2;
      end else if (c >= AW'(5)) begin
         coin_code = 2'd1;
      end else begin
         coin_code = 2'd0;
      end
   endfunction

   function automatic logic [AW-1:0] coin_value(input logic [1:0] code);
      case (code)
         2'd2:    coin_value = AW'(10);
         2'd1:    coin_value = AW'(5);
         default: coin_value = AW'(1);
      endcase
   endfunction

   // Next-state, credit update and pulse generation.
   always_comb begin
      state_s      = state_r;
      credit_s     = credit_r;
      vend_idx_s   = vend_idx_r;
      coin_rej_s   = 1'b0;
      sel_deny_s   = 1'b0;
      credit_ext_s = {1'b0, credit_r};
      any_coin_s   = coin1 | coin5 | coin10;
      sum_s        = (coin1 ? AW'(1) : AW'(0)) + (coin5 ? AW'(5) : AW'(0))
                   + (coin10 ? AW'(10) : AW'(0));
      coined_s     = credit_ext_s;
      price_s      = price_of(sel_idx);
      paid_s       = credit_ext_s - coin_value(chg_coin_r);
      case (state_r)
         IDLE: begin
            // Coins are judged on pre-edge credit, the selection on post-coin credit.
            if (any_coin_s) begin
               if ((credit_ext_s + sum_s) > AW'(MAX_CREDIT)) begin
                  coin_rej_s = 1'b1;
               end else begin
                  coined_s = credit_ext_s + sum_s;
               end
            end else begin
               coined_s = credit_ext_s;
            end
            credit_s = coined_s[CREDIT_W-1:0];
            if (cancel) begin
               if (coined_s != AW'(0)) begin
                  state_s = CHANGE;
               end else begin
                  state_s = IDLE;
               end
            end else if (sel_valid) begin
               if ((32'(sel_idx) >= 32'(N_ITEMS)) || (coined_s < price_s)) begin
                  sel_deny_s = 1'b1;
               end else begin
                  credit_s   = CREDIT_W'(coined_s - price_s);
                  vend_idx_s = sel_idx;
                  state_s    = VEND;
               end
            end else begin
               state_s = IDLE;
            end
         end
         VEND: begin
            coin_rej_s = any_coin_s;
            if (vend_ready) begin
               if (credit_r != CREDIT_W'(0)) begin
                  state_s = CHANGE;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = VEND;
            end
         end
         CHANGE: begin
            coin_rej_s = any_coin_s;
            if (chg_ready) begin
               credit_s = paid_s[CREDIT_W-1:0];
               if (paid_s == AW'(0)) begin
                  state_s = IDLE;
               end else begin
                  state_s = CHANGE;
               end
            end else begin
               state_s = CHANGE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and registered outputs; handshake outputs are derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         credit_r     <= '0;
         vend_idx_r   <= '0;
         vend_valid_r <= 1'b0;
         chg_valid_r  <= 1'b0;
         chg_coin_r   <= 2'd0;
         coin_rej_r   <= 1'b0;
         sel_deny_r   <= 1'b0;
      end else begin
         state_r      <= state_s;
         credit_r     <= credit_s;
         vend_idx_r   <= (state_s == VEND) ? vend_idx_s : '0;
         vend_valid_r <= (state_s == VEND);
         chg_valid_r  <= (state_s == CHANGE);
         chg_coin_r   <= (state_s == CHANGE) ? coin_code({1'b0, credit_s}) : 2'd0;
         coin_rej_r   <= coin_rej_s;
         sel_deny_r   <= sel_deny_s;
      end
   end

   assign vend_valid = vend_valid_r;
   assign vend_idx   = vend_idx_r;
   assign chg_valid  = chg_valid_r;
   assign chg_coin   = chg_coin_r;
   assign credit     = credit_r;
   assign coin_rej   = coin_rej_r;
   assign sel_deny   = sel_deny_r;

endmodule

// File: tb/tb_vend_ctrl.sv
// Table-driven bench for vend_ctrl with a one-cycle-latency scoreboard queue,
// plus a hand-written sequence on a second instance with swept parameters.
module tb_vend_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance: IDX_W=3 so an out-of-range index (4) can be presented.
   logic       rst, coin1, coin5, coin10, sel_valid, cancel, vend_ready, chg_ready;
   logic [2:0] sel_idx, vend_idx;
   logic       vend_valid, chg_valid, coin_rej, sel_deny;
   logic [1:0] chg_coin;
   logic [7:0] credit;

   vend_ctrl #(.CREDIT_W(8), .N_ITEMS(4), .IDX_W(3), .PRICE_BASE(5), .PRICE_STEP(5),
               .MAX_CREDIT(99)) dut (
      .clk(clk), .rst(rst), .coin1(coin1), .coin5(coin5), .coin10(coin10),
      .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel),
      .vend_valid(vend_valid), .vend_idx(vend_idx), .vend_ready(vend_ready),
      .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ready(chg_ready),
      .credit(credit), .coin_rej(coin_rej), .sel_deny(sel_deny));

   // Swept instance: prices 3, 7, 11; ceiling 50.
   logic       s_rst, s_coin1, s_coin5, s_coin10, s_sel_valid, s_cancel, s_vend_ready, s_chg_ready;
   logic [1:0] s_sel_idx, s_vend_idx, s_chg_coin;
   logic       s_vend_valid, s_chg_valid, s_coin_rej, s_sel_deny;
   logic [5:0] s_credit;

   vend_ctrl #(.CREDIT_W(6), .N_ITEMS(3), .IDX_W(2), .PRICE_BASE(3), .PRICE_STEP(4),
               .MAX_CREDIT(50)) dut2 (
      .clk(clk), .rst(s_rst), .coin1(s_coin1), .coin5(s_coin5), .coin10(s_coin10),
      .sel_valid(s_sel_valid), .sel_idx(s_sel_idx), .cancel(s_cancel),
      .vend_valid(s_vend_valid), .vend_idx(s_vend_idx), .vend_ready(s_vend_ready),
      .chg_valid(s_chg_valid), .chg_coin(s_chg_coin), .chg_ready(s_chg_ready),
      .credit(s_credit), .coin_rej(s_coin_rej), .sel_deny(s_sel_deny));

   typedef struct {
      logic       r, c1, c5, c10, sv;
      logic [2:0] si;
      logic       cn, vr, cr;
      logic       evv;
      logic [2:0] evi;
      logic       ecv;
      logic [1:0] ecc;
      logic [7:0] ecr;
      logic       erj, esd;
   } vec_t;

   vec_t tbl[$];
   vec_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic add(input logic r, c1, c5, c10, sv, input logic [2:0] si,
                      input logic cn, vr, cr, input logic evv, input logic [2:0] evi,
                      input logic ecv, input logic [1:0] ecc, input logic [7:0] ecr,
                      input logic erj, esd);
      vec_t v;
      v.r = r; v.c1 = c1; v.c5 = c5; v.c10 = c10; v.sv = sv; v.si = si;
      v.cn = cn; v.vr = vr; v.cr = cr;
      v.evv = evv; v.evi = evi; v.ecv = ecv; v.ecc = ecc; v.ecr = ecr;
      v.erj = erj; v.esd = esd;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s step %0d: got %0d, expected %0d", nm, idx, act, exp);
      end
   endtask

   function automatic logic [1:0] code_of(input int c);
      code_of = (c >= 10) ? 2'd2 : (c >= 5) ? 2'd1 : 2'd0;
   endfunction

   // Drives one cycle on the swept instance.
   task automatic s_cyc(input logic r, c1, sv, input logic [1:0] si, input logic vr);
      s_rst = r; s_coin1 = c1; s_sel_valid = sv; s_sel_idx = si; s_vend_ready = vr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t e;
      int   c;
      rst = 1'b1; coin1 = 1'b0; coin5 = 1'b0; coin10 = 1'b0; sel_valid = 1'b0;
      sel_idx = 3'd0; cancel = 1'b0; vend_ready = 1'b0; chg_ready = 1'b0;
      s_rst = 1'b1; s_coin1 = 1'b0; s_coin5 = 1'b0; s_coin10 = 1'b0; s_sel_valid = 1'b0;
      s_sel_idx = 2'd0; s_cancel = 1'b0; s_vend_ready = 1'b0; s_chg_ready = 1'b0;

      //  r c1 c5 c10 sv si cn vr cr | vv vi cv cc credit rj sd
      add(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0);
      // coin10, coin5, buy item 1, vend, one 5-coin change
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 10, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 15, 0, 0);
      add(0, 0, 0, 0, 1, 1, 0, 0, 0,   1, 1, 0, 0, 5,  0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 5,  0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1, 5,  0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 5,  0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0,  0, 0);
      // all three coins at once, cancel, change 10/5/1 with ready toggling; coin in CHANGE rejected
      add(0, 1, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 16, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 2, 16, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 6,  0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 6,  1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 1,  0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1,  0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0,  0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0,  0, 0);
      // build up to 95, overflow rejections (consecutive), exact fill to 99
      for (int k = 1; k <= 5; k++) add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'(16 * k), 0, 0);
      add(0, 0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 95, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 95, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 95, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 95, 0, 0);
      for (int k = 96; k <= 99; k++) add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'(k), 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 99, 1, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 2, 99, 0, 0);
      c = 99;
      while (c > 0) begin
         c -= (c >= 10) ? 10 : (c >= 5) ? 5 : 1;
         add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c > 0, code_of(c), 8'(c), 0, 0);
      end
      // denials (consecutive, too expensive, out of range), vend at exact price, coin in VEND
      add(0, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 5,  0, 0);
      add(0, 0, 0, 0, 1, 3, 0, 0, 0,   0, 0, 0, 0, 5,  0, 1);
      add(0, 0, 0, 0, 1, 3, 0, 0, 0,   0, 0, 0, 0, 5,  0, 1);
      add(0, 0, 0, 0, 1, 4, 0, 0, 0,   0, 0, 0, 0, 5,  0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 5,  0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0,  0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0,  1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0,  0, 0);
      // coins and selection on the same edge
      add(0, 0, 1, 1, 1, 2, 0, 0, 0,   1, 2, 0, 0, 0,  0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0,  0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 10, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 20, 0, 0);
      add(0, 0, 0, 0, 1, 3, 0, 0, 0,   1, 3, 0, 0, 0,  0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0,  0, 0);
      // cancel beats selection
      add(0, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 5,  0, 0);
      add(0, 0, 0, 0, 1, 0, 1, 0, 0,   0, 0, 1, 1, 5,  0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0,  0, 0);
      // reset mid-CHANGE (credit 11) and mid-VEND
      add(0, 1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 11, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 2, 11, 0, 0);
      add(1, 0, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0,  0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 5,  0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0,  0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0,  0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0);

      foreach (tbl[i]) begin
         rst = tbl[i].r; coin1 = tbl[i].c1; coin5 = tbl[i].c5; coin10 = tbl[i].c10;
         sel_valid = tbl[i].sv; sel_idx = tbl[i].si; cancel = tbl[i].cn;
         vend_ready = tbl[i].vr; chg_ready = tbl[i].cr;
         sb_q.push_back(tbl[i]);
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         chk("vend_valid", i, 32'(vend_valid), 32'(e.evv));
         chk("vend_idx",   i, 32'(vend_idx),   32'(e.evi));
         chk("chg_valid",  i, 32'(chg_valid),  32'(e.ecv));
         chk("chg_coin",   i, 32'(chg_coin),   32'(e.ecc));
         chk("credit",     i, 32'(credit),     32'(e.ecr));
         chk("coin_rej",   i, 32'(coin_rej),   32'(e.erj));
         chk("sel_deny",   i, 32'(sel_deny),   32'(e.esd));
         chk("vend_chg_excl", i, 32'(vend_valid & chg_valid), 32'd0);
      end
      rst = 1'b0; coin1 = 1'b0; coin5 = 1'b0; coin10 = 1'b0; sel_valid = 1'b0;
      cancel = 1'b0; vend_ready = 1'b0; chg_ready = 1'b0;

      // Swept instance: three 1-unit coins buy item 0 (price 3) with no change
      s_cyc(1, 0, 0, 2'd0, 0);
      chk("s_reset_credit", 0, 32'(s_credit), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         s_cyc(0, 1, 0, 2'd0, 0);
         chk("s_credit_coin", k, 32'(s_credit), 32'(k));
      end
      s_cyc(0, 0, 1, 2'd0, 0);
      chk("s_vend_valid", 4, 32'(s_vend_valid), 32'd1);
      chk("s_vend_idx",   4, 32'(s_vend_idx),   32'd0);
      chk("s_credit_vend", 4, 32'(s_credit),    32'd0);
      s_cyc(0, 0, 0, 2'd0, 1);
      chk("s_vend_done", 5, 32'(s_vend_valid), 32'd0);
      chk("s_no_change", 5, 32'(s_chg_valid),  32'd0);
      s_cyc(0, 0, 1, 2'd1, 0);
      chk("s_no_change_later", 6, 32'(s_chg_valid), 32'd0);
      chk("s_sel_deny", 6, 32'(s_sel_deny), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 The block SHALL take parameters:
  CREDIT_W, default 8, credit register width.
  N_ITEMS, default 4, product count.
  IDX_W, default 2, width of sel_idx/vend_idx; 2**IDX_W >= N_ITEMS.
  PRICE_BASE, default 5, price of item 0.
  PRICE_STEP, default 5, price increment per index; price(i) = PRICE_BASE + i*PRICE_STEP.
  MAX_CREDIT, default 99, credit ceiling; MAX_CREDIT < 2**CREDIT_W.
REQ-002 The block SHALL have ports:
  clk  in  1  clock, all state on rising edge.
  rst  in  1  reset, synchronous, active-high.
  coin1  in  1  one-cycle pulse, 1-unit coin inserted.
  coin5  in  1  one-cycle pulse, 5-unit coin inserted.
  coin10  in  1  one-cycle pulse, 10-unit coin inserted.
  sel_valid  in  1  product request strobe.
  sel_idx  in  IDX_W  requested product.
  cancel  in  1  return all credit.
  vend_valid  out  1  product dispense request.
  vend_idx  out  IDX_W  product being dispensed.
  vend_ready  in  1  dispenser accepts product.
  chg_valid  out  1  change coin offered.
  chg_coin  out  2  denomination code: 0=1, 1=5, 2=10.
  chg_ready  in  1  coin hopper accepts coin.
  credit  out  CREDIT_W  current credit, registered.
  coin_rej  out  1  one-cycle pulse, inserted coin(s) returned unaccepted.
  sel_deny  out  1  one-cycle pulse, selection refused.

Function
REQ-003 The FSM SHALL have states IDLE, VEND, CHANGE; coins, selections and cancel are acted on only in IDLE.
REQ-004 In IDLE, the coin sum S = coin1 + 5*coin5 + 10*coin10 SHALL be added to credit on the same edge; simultaneous coins are summed.
REQ-005 If credit + S > MAX_CREDIT, the whole cycle's coins SHALL be rejected: credit unchanged, coin_rej=1 for the next cycle.
REQ-006 Any coin pulse in VEND or CHANGE SHALL be rejected with coin_rej=1 the next cycle.
REQ-007 In IDLE, sel_valid with sel_idx >= N_ITEMS or credit < price(sel_idx) SHALL produce sel_deny=1 the next cycle and no state change.
REQ-008 In IDLE, a valid, affordable selection SHALL, on that edge, subtract price(sel_idx) from credit, latch vend_idx, and enter VEND; vend_valid=1 from the next cycle.
REQ-009 In IDLE, coins SHALL be evaluated against pre-edge credit, then the selection against post-coin credit. Both take effect on the same edge.
REQ-010 Cancel SHALL take priority over sel_valid.
REQ-011 In IDLE, cancel with credit > 0 SHALL enter CHANGE. Cancel with credit = 0 SHALL be ignored.
REQ-012 vend_valid and vend_idx SHALL hold stable until vend_ready=1 is sampled. On that edge: if credit > 0, enter CHANGE; else enter IDLE.
REQ-013 In CHANGE, chg_valid SHALL be 1 and chg_coin SHALL select the largest denomination <= credit: 10, then 5, then 1.
REQ-014 chg_coin SHALL hold stable while chg_ready=0.
REQ-015 On each edge with chg_valid && chg_ready, credit SHALL decrease by the offered value; reaching 0 SHALL enter IDLE with chg_valid=0 the next cycle.
REQ-016 Change delivery SHALL be one coin per accepted handshake, so N coins take at least N cycles.
REQ-017 vend_valid and chg_valid SHALL never both be 1.
REQ-018 Credit arithmetic SHALL be performed in CREDIT_W+1 bits; credit SHALL never exceed MAX_CREDIT or go below 0.
REQ-019 coin_rej and sel_deny SHALL be registered single-cycle pulses. They SHALL not stretch, even if the cause repeats on consecutive cycles; each cause cycle yields one pulse cycle.

Reset
REQ-020 rst=1 SHALL, on the next edge, force state IDLE and credit=0, and force vend_valid, chg_valid, coin_rej and sel_deny to 0. It SHALL also set vend_idx=0 and chg_coin=0.
REQ-021 Reset SHALL override every input, including mid-VEND or mid-CHANGE. Pending product and change are abandoned.
REQ-022 The first functional edge SHALL be the first edge with rst=0.

Verification
REQ-023 coin10, then coin5, then sel_idx=1 (price 10) -> credit 10, 15, 5. vend_valid with vend_idx=1 until vend_ready. Then CHANGE emits one chg_coin=1 (5) and returns to IDLE with credit 0.
REQ-024 coin1+coin5+coin10 in one cycle, then cancel -> credit 16. Change emitted in order 10, 5, 1. With chg_ready toggling 1,0,1,0,1, chg_coin holds while chg_ready=0 and the sequence finishes on the 5th cycle.
REQ-025 credit 95, coin10 -> coin_rej pulse, credit stays 95. Then coin1 -> credit 96.
REQ-026 credit 5, sel_idx=3 (price 20) -> sel_deny one cycle, credit 5. sel_idx=4 with N_ITEMS=4 -> sel_deny. Coin5 during VEND -> coin_rej, credit unchanged.
REQ-027 rst asserted while in CHANGE with credit 11 -> next cycle IDLE, credit 0, chg_valid 0. Then coin5 -> credit 5.
REQ-028 Parameter sweep CREDIT_W=6, N_ITEMS=3, PRICE_BASE=3, PRICE_STEP=4, MAX_CREDIT=50 -> coin1, coin1, coin1, sel_idx=0 vends item 0 with credit 0 and no CHANGE state.
